rd_xbar_mxn_pkt: RTL and testbench
==================================

Name: rd_xbar_mxn_pkt

Overview:
- Parametrised NIN-input, NOUT-output read-data crossbar for the switch read path; successor to the fixed 16x4 crossbar.
- Each output runs its own round-robin arbiter. A grant is locked for a whole packet, so beats of different packets never interleave on one output.
- Each output has a registered, full-throughput pipeline stage.
- Sits between the per-port buffer read engines (inputs) and the egress ports (outputs).

Parameters:
- NIN, 16, number of input channels (2..32).
- NOUT, 4, number of output channels (2..16).
- DW, 33, payload width; Pld[DW-1] is the end-of-packet (EOP) flag.
- AW, 4, Dst field width; must satisfy AW >= SELW = max(1, clog2(NOUT)).

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-high reset.
- iVld  in  NIN  per-input beat valid.
- iPld  in  NIN*DW  per-input payload; input i occupies bits [i*DW +: DW].
- iDst  in  NIN*AW  per-input destination; input i occupies bits [i*AW +: AW].
- iRdy  out  NIN  per-input ready.
- oVld  out  NOUT  per-output valid.
- oPld  out  NOUT*DW  per-output payload.
- oDst  out  NOUT*AW  per-output destination, passed through unchanged.
- oRdy  in  NOUT  per-output ready from the egress side.
- oDstErr  out  NIN  per-input level flag: iVld[i] is high and iDst[i] >= NOUT.

Behaviour:
- Transfer rule: a beat transfers when Vld && Rdy on the same edge. Sources hold Vld, Pld and Dst stable until accepted.
- Request: req[o][i] = iVld[i] && (iDst[i] == o). An input with Dst >= NOUT requests nothing. It is never accepted and stalls, and oDstErr[i] stays high while the condition holds.
- Output stage: one register per output holding Vld, Pld and Dst.
  - can_acc[o] = !oVld[o] || oRdy[o].
  - On an accepted input beat the register loads. Otherwise, if oRdy[o] is high, oVld[o] clears.
  - Latency: 1 cycle from input transfer to oVld.
  - Throughput: 1 beat/cycle per output under continuous oRdy.
- Arbiter FSM, per output, states IDLE and LOCKED:
  - IDLE: the winner is the first requester searching from ptr[o]+1 upward, modulo NIN. Grant is combinational.
  - IDLE, winner beat accepted and EOP=1: stay IDLE, ptr[o] <= winner.
  - IDLE, winner beat accepted and EOP=0: go to LOCKED, owner[o] <= winner, ptr[o] <= winner.
  - LOCKED: only owner[o] is granted; all other requesters get iRdy=0. An accepted beat with EOP=1 returns the FSM to IDLE.
  - If the owner drops Vld or changes Dst mid-packet, the output stalls in LOCKED and no other input is served. This is a protocol violation by the source; no recovery is required.
- iRdy[i] = grant[o][i] && can_acc[o], where o = iDst[i]. It is 0 when iVld[i] is low or Dst is out of range. iRdy is combinational from iVld, iDst, oRdy and state; there is no combinational path from iPld.
- Each input targets only one output per cycle, so there are no conflicts across outputs. Different outputs can accept beats from different inputs in the same cycle.
- Reset (asynchronous, any time, including mid-packet):
  - oVld=0, all FSMs IDLE, ptr[o]=NIN-1 (input 0 has first priority), owner=0.
  - oPld and oDst are don't-care.
  - A partial packet in flight is abandoned; no EOP is synthesised.
  - iRdy and oDstErr follow their combinational definitions.
- Simultaneous events: in one cycle the register drains (oRdy) and loads a new beat. A new packet grant happens in the same cycle the previous owner's EOP beat is accepted only on the next cycle; exactly one IDLE cycle evaluation precedes each new packet.

Test Plan:
- Single beat: input 5 sends Dst=2, Pld EOP=1, oRdy=1 -> iRdy[5]=1 in the same cycle; oVld[2]=1 with the same Pld and Dst=2 one cycle later; other outputs stay 0.
- Round-robin: after reset, inputs 0, 3 and 9 each continuously send single-beat packets to output 1 -> acceptance order 0, 3, 9, 0, 3, 9; no input is skipped.
- Packet lock: input 2 sends a 4-beat packet to output 0 while input 7 requests output 0 from cycle 1 -> all 4 beats of input 2 appear contiguously; input 7 gets iRdy=0 until input 2's EOP is accepted, and its beat follows after.
- Backpressure: stream to output 3, hold oRdy[3]=0 for 5 cycles mid-stream -> oVld and oPld held constant, iRdy of the source is 0 after the register fills, no beat lost or duplicated; full rate resumes once oRdy rises.
- Parallelism and throughput: inputs 0..3 send 8-beat packets to outputs 0..3 with all oRdy=1 -> all four outputs deliver 1 beat/cycle concurrently, 8 consecutive cycles each.
- Reset mid-packet and error: assert iRst after beat 2 of a 5-beat packet -> oVld=0 immediately, next grant goes to input 0. Input 4 sending Dst=4 with NOUT=4 -> oDstErr[4]=1, iRdy[4]=0, no output activity.

Source files
------------

// File: rtl/rd_xbar_mxn_pkt_if.sv
// Handshake bundle for the packet read-data crossbar: NIN source channels
// in, NOUT egress channels out, plus the per-input bad-destination flags.
interface rd_xbar_mxn_pkt_if #(
  parameter int NIN  = 16,
  parameter int NOUT = 4,
  parameter int DW   = 33,
  parameter int AW   = 4
);
  logic [NIN-1:0]       iVld;
  logic [NIN*DW-1:0]    iPld;
  logic [NIN*AW-1:0]    iDst;
  logic [NIN-1:0]       iRdy;
  logic [NOUT-1:0]      oVld;
  logic [NOUT*DW-1:0]   oPld;
  logic [NOUT*AW-1:0]   oDst;
  logic [NOUT-1:0]      oRdy;
  logic [NIN-1:0]       oDstErr;

  modport slave (
    input  iVld, iPld, iDst, oRdy,
    output iRdy, oVld, oPld, oDst, oDstErr
  );

  modport master (
    output iVld, iPld, iDst, oRdy,
    input  iRdy, oVld, oPld, oDst, oDstErr
  );
endinterface

// File: rtl/rd_xbar_mxn_pkt.sv
// NIN x NOUT read-data crossbar: per-output round-robin arbiter that locks onto
// a packet until its EOP beat, feeding a single full-throughput output register.
module rd_xbar_mxn_pkt #(
  parameter int NIN  = 16,
  parameter int NOUT = 4,
  parameter int DW   = 33,
  parameter int AW   = 4
) (
  input logic               iClk,
  input logic               iRst,
  rd_xbar_mxn_pkt_if.slave  bus
);
  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [NOUT-1:0][NIN-1:0] grant;
  logic [NOUT-1:0]          can_acc;
  logic [NOUT-1:0]          out_vld;
  logic [NOUT-1:0][DW-1:0]  out_pld;
  logic [NOUT-1:0][AW-1:0]  out_dst;
  logic [NIN-1:0]           rdy;
  logic [NIN-1:0]           dst_err;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
    logic [NIN-1:0] req;
    logic [IW-1:0]  win;
    logic [IW-1:0]  sel;
    logic           win_found;
    logic           have;
    logic           acc;
    logic [DW-1:0]  beat_pld;
    logic [AW-1:0]  beat_dst;
    logic [0:0]     state_reg, state_next;
    logic [IW-1:0]  ptr_reg, ptr_next;
    logic [IW-1:0]  owner_reg, owner_next;
    logic           vld_reg;
    logic [DW-1:0]  pld_reg;
    logic [AW-1:0]  dst_reg;

    always_comb begin
      req = '0;
      for (int i = 0; i < NIN; i++) begin
        req[i] = bus.iVld[i] && (bus.iDst[i*AW +: AW] == AW'(gi));
      end
    end

    // First requester strictly after ptr, wrapping at NIN; k runs downward so
    // the closest candidate is the last one written.
    always_comb begin
      logic [IW:0] idx;
      win       = '0;
      win_found = 1'b0;
      idx       = '0;
      for (int k = NIN; k >= 1; k--) begin
        idx = {1'b0, ptr_reg} + (IW+1)'(k);
        if (idx >= (IW+1)'(NIN)) idx = idx - (IW+1)'(NIN);
        if (req[idx[IW-1:0]]) begin
          win       = idx[IW-1:0];
          win_found = 1'b1;
        end
      end
    end

    assign sel          = (state_reg == ST_LOCKED) ? owner_reg : win;
    assign have         = (state_reg == ST_LOCKED) ? req[owner_reg] : win_found;
    assign can_acc[gi]  = !vld_reg || bus.oRdy[gi];
    assign acc          = have && can_acc[gi];
    assign grant[gi]    = have ? (NIN'(1) << sel) : '0;

    always_comb begin
      beat_pld = '0;
      beat_dst = '0;
      for (int i = 0; i < NIN; i++) begin
        if (sel == IW'(i)) begin
          beat_pld = bus.iPld[i*DW +: DW];
          beat_dst = bus.iDst[i*AW +: AW];
        end
      end
    end

    always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      if (acc) begin
        ptr_next = sel;
        if (beat_pld[DW-1]) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_LOCKED;
          owner_next = sel;
        end
      end
    end

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        state_reg <= ST_IDLE;
        ptr_reg   <= IW'(NIN-1);
        owner_reg <= '0;
        vld_reg   <= 1'b0;
        pld_reg   <= '0;
        dst_reg   <= '0;
      end else begin
        state_reg <= state_next;
        ptr_reg   <= ptr_next;
        owner_reg <= owner_next;
        if (acc) begin
          vld_reg <= 1'b1;
          pld_reg <= beat_pld;
          dst_reg <= beat_dst;
        end else if (bus.oRdy[gi]) begin
          vld_reg <= 1'b0;
        end
      end
    end

    assign out_vld[gi] = vld_reg;
    assign out_pld[gi] = pld_reg;
    assign out_dst[gi] = dst_reg;
  end

  // An input only ever requests the output named by its Dst, so OR-ing over
  // outputs never merges two grants for the same input.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < NIN; i++) begin
      for (int o = 0; o < NOUT; o++) begin
        rdy[i] = rdy[i] | (grant[o][i] & can_acc[o]);
      end
    end
  end

  always_comb begin
    dst_err = '0;
    for (int i = 0; i < NIN; i++) begin
      dst_err[i] = bus.iVld[i] && (int'(bus.iDst[i*AW +: AW]) >= NOUT);
    end
  end

  assign bus.iRdy    = rdy;
  assign bus.oDstErr = dst_err;
  assign bus.oVld    = out_vld;
  assign bus.oPld    = out_pld;
  assign bus.oDst    = out_dst;
endmodule

// File: tb/tb_rd_xbar_mxn_pkt.sv
// Directed bench for rd_xbar_mxn_pkt: per-input beat queues drive the sources,
// accepted beats go to a per-output scoreboard checked at the egress side.
module tb_rd_xbar_mxn_pkt;
  localparam int NIN  = 16;
  localparam int NOUT = 4;
  localparam int DW   = 33;
  localparam int AW   = 4;

  typedef struct packed {
    logic [7:0]    src;
    logic [AW-1:0] dst;
    logic [DW-1:0] pld;
  } beat_t;

  logic iClk;
  logic iRst;

  rd_xbar_mxn_pkt_if #(.NIN(NIN), .NOUT(NOUT), .DW(DW), .AW(AW)) bus ();

  rd_xbar_mxn_pkt #(.NIN(NIN), .NOUT(NOUT), .DW(DW), .AW(AW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  beat_t          src_q [NIN][$];
  beat_t          exp_q [NOUT][$];
  int             acc_log [NOUT][$];
  int             out_log [NOUT][$];
  logic [NIN-1:0] in_acc;
  int             n_tests;
  int             n_fail;
  int             seq_ctr;

  int rr_exp[6]   = '{0, 3, 9, 0, 3, 9};
  int lock_exp[5] = '{2, 2, 2, 2, 7};

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] make_pld(int src, int seq, bit eop);
    return {eop, 8'(src), 24'(seq)};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(int src, int dst, int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.src = 8'(src);
      b.dst = AW'(dst);
      b.pld = make_pld(src, seq_ctr + k, k == nbeats - 1);
      src_q[src].push_back(b);
    end
    seq_ctr += nbeats;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge iClk);
      #2;
    end
  endtask

  task automatic wait_drain(string tag);
    int cyc;
    bit busy;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 300) begin
      @(negedge iClk);
      cyc++;
      busy = (bus.iVld != '0) || (bus.oVld != '0);
      for (int o = 0; o < NOUT; o++) if (exp_q[o].size() != 0) busy = 1'b1;
      for (int i = 0; i < NIN; i++) if (src_q[i].size() != 0) busy = 1'b1;
    end
    n_tests++;
    assert (!busy) else begin
      n_fail++;
      $error("FAIL %s_drain: observed busy after %0d cycles, expected idle", tag, cyc);
    end
  endtask

  // Source model: pop the head once it was seen accepted, present the next one.
  always @(posedge iClk) begin
    #1;
    for (int i = 0; i < NIN; i++) begin
      if (in_acc[i] && src_q[i].size() != 0) src_q[i].delete(0);
      if (src_q[i].size() != 0) begin
        bus.iVld[i]           = 1'b1;
        bus.iPld[i*DW +: DW]  = src_q[i][0].pld;
        bus.iDst[i*AW +: AW]  = src_q[i][0].dst;
      end else begin
        bus.iVld[i] = 1'b0;
      end
    end
  end

  // Monitor: handshakes seen here take effect on the following rising edge.
  always @(negedge iClk) begin
    beat_t e;
    int    d;
    if (iRst) begin
      in_acc = '0;
      for (int o = 0; o < NOUT; o++) exp_q[o].delete();
    end else begin
      for (int o = 0; o < NOUT; o++) begin
        if (bus.oVld[o] && bus.oRdy[o]) begin
          n_tests++;
          assert (exp_q[o].size() != 0) else begin
            n_fail++;
            $error("FAIL out%0d_extra: observed pld=%0h, expected no beat", o, bus.oPld[o*DW +: DW]);
          end
          if (exp_q[o].size() != 0) begin
            e = exp_q[o].pop_front();
            chk($sformatf("out%0d_pld", o), 64'(bus.oPld[o*DW +: DW]), 64'(e.pld));
            chk($sformatf("out%0d_dst", o), 64'(bus.oDst[o*AW +: AW]), 64'(e.dst));
            out_log[o].push_back(int'(e.src));
            $display("[TB] out%0d beat src=%0d pld=%h", o, e.src, bus.oPld[o*DW +: DW]);
          end
        end
      end
      for (int i = 0; i < NIN; i++) begin
        in_acc[i] = bus.iVld[i] && bus.iRdy[i];
        if (in_acc[i]) begin
          d = int'(bus.iDst[i*AW +: AW]);
          n_tests++;
          assert (d < NOUT) else begin
            n_fail++;
            $error("FAIL in%0d_bad_accept: observed accept of dst=%0d, expected stall", i, d);
          end
          if (d < NOUT) begin
            e.src = 8'(i);
            e.dst = AW'(d);
            e.pld = bus.iPld[i*DW +: DW];
            exp_q[d].push_back(e);
            acc_log[d].push_back(i);
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] p;
    n_tests = 0;
    n_fail  = 0;
    seq_ctr = 1;
    in_acc  = '0;
    iRst    = 1'b1;
    bus.oRdy = '1;
    bus.iVld = '0;
    bus.iPld = '0;
    bus.iDst = '0;
    tick(2);
    @(negedge iClk);
    chk("rst_ovld", 64'(bus.oVld), 0);
    chk("rst_irdy", 64'(bus.iRdy), 0);
    chk("rst_dsterr", 64'(bus.oDstErr), 0);
    tick(1);
    iRst = 1'b0;
    tick(1);

    // Single beat 5 -> 2
    p = make_pld(5, seq_ctr, 1'b1);
    push_pkt(5, 2, 1);
    @(posedge iClk);
    @(negedge iClk);
    chk("t1_irdy5", 64'(bus.iRdy[5]), 1);
    chk("t1_ovld_pre", 64'(bus.oVld), 0);
    @(negedge iClk);
    chk("t1_ovld", 64'(bus.oVld), 64'b0100);
    chk("t1_opld", 64'(bus.oPld[2*DW +: DW]), 64'(p));
    chk("t1_odst", 64'(bus.oDst[2*AW +: AW]), 2);
    wait_drain("t1");
    tick(1);

    // Round robin among 0, 3, 9 on output 1
    acc_log[1].delete();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 1, 1);
      push_pkt(3, 1, 1);
      push_pkt(9, 1, 1);
    end
    wait_drain("t2");
    chk("t2_count", 64'(acc_log[1].size()), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), 64'(acc_log[1][k]), 64'(rr_exp[k]));
    tick(1);

    // Packet lock: input 2 holds output 0 for 4 beats, input 7 waits
    acc_log[0].delete();
    out_log[0].delete();
    push_pkt(2, 0, 4);
    tick(1);
    push_pkt(7, 0, 1);
    @(negedge iClk);
    @(negedge iClk);
    chk("t3_irdy7_locked", 64'(bus.iRdy[7]), 0);
    chk("t3_irdy2_owner", 64'(bus.iRdy[2]), 1);
    wait_drain("t3");
    chk("t3_count", 64'(out_log[0].size()), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), 64'(out_log[0][k]), 64'(lock_exp[k]));
    tick(1);

    // Backpressure on output 3
    push_pkt(11, 3, 8);
    tick(3);
    bus.oRdy[3] = 1'b0;
    @(negedge iClk);
    p = bus.oPld[3*DW +: DW];
    chk("t4_hold_vld", 64'(bus.oVld[3]), 1);
    chk("t4_hold_irdy", 64'(bus.iRdy[11]), 0);
    repeat (4) begin
      @(negedge iClk);
      chk("t4_hold_vld", 64'(bus.oVld[3]), 1);
      chk("t4_hold_pld", 64'(bus.oPld[3*DW +: DW]), 64'(p));
      chk("t4_hold_irdy", 64'(bus.iRdy[11]), 0);
    end
    tick(1);
    bus.oRdy[3] = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      chk("t4_resume_vld", 64'(bus.oVld[3]), 1);
      chk("t4_resume_irdy", 64'(bus.iRdy[11]), 1);
    end
    wait_drain("t4");
    tick(1);

    // Four concurrent 8-beat streams
    for (int i = 0; i < 4; i++) push_pkt(i, i, 8);
    @(posedge iClk);
    @(negedge iClk);
    chk("t5_irdy", 64'(bus.iRdy[3:0]), 64'hF);
    repeat (8) begin
      @(negedge iClk);
      chk("t5_ovld", 64'(bus.oVld), 64'hF);
    end
    wait_drain("t5");
    tick(1);

    // Reset after beat 2 of a 5-beat packet, then priority restarts at input 0
    push_pkt(6, 0, 5);
    @(posedge iClk);
    @(posedge iClk);
    @(posedge iClk);
    #1;
    chk("t6_ovld_pre", 64'(bus.oVld[0]), 1);
    #1;
    iRst = 1'b1;
    src_q[6].delete();
    #1;
    chk("t6_ovld_async", 64'(bus.oVld), 0);
    tick(2);
    iRst = 1'b0;
    acc_log[0].delete();
    tick(1);
    push_pkt(0, 0, 1);
    push_pkt(8, 0, 1);
    wait_drain("t6");
    chk("t6_count", 64'(acc_log[0].size()), 2);
    chk("t6_first", 64'(acc_log[0][0]), 0);
    chk("t6_second", 64'(acc_log[0][1]), 8);
    tick(1);

    // Out-of-range destination
    push_pkt(4, 4, 1);
    @(posedge iClk);
    @(negedge iClk);
    chk("t7_dsterr", 64'(bus.oDstErr), 64'h0010);
    chk("t7_irdy4", 64'(bus.iRdy[4]), 0);
    repeat (3) begin
      @(negedge iClk);
      chk("t7_ovld", 64'(bus.oVld), 0);
    end
    src_q[4].delete();
    tick(1);
    @(negedge iClk);
    chk("t7_dsterr_clear", 64'(bus.oDstErr), 0);
    wait_drain("t7");

    for (int o = 0; o < NOUT; o++) chk($sformatf("end_empty%0d", o), 64'(exp_q[o].size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
